// File: rtl/alu_seq.sv
// Multi-cycle ALU: valid/ready operand handshake, registered result and a
// persistent {N,Z,F,L,C} flag register. Shifts run one bit per cycle, MUL is shift-add.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for in_valid
//   SHIFT | shifting latched rsrc one bit per cycle
//   MUL   | shift-add multiply, one multiplier bit per cycle
//   DONE  | out_valid (and op_err) pulse, result/flags just updated
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   rsrc,
  input  logic [WIDTH-1:0]   rdest,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [4:0]         flags,
  output logic               op_err
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_CMP  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_LSH  = 5'd7;
  localparam logic [4:0] OP_RSH  = 5'd8;
  localparam logic [4:0] OP_ARSH = 5'd9;
  localparam logic [4:0] OP_MUL  = 5'd10;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

  state_t               state_q, state_d;
  logic [4:0]           op_q, op_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [WIDTH-1:0]     mc_q, mc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [4:0]           flags_q, flags_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic [WIDTH-1:0]     b_op, sh_next;
  logic [WIDTH:0]       sum, mul_add;
  logic                 ovf, rel_z, rel_l, rel_n;

  // SUB reuses the adder as rdest + ~rsrc + 1, so C means "no borrow".
  always_comb begin
    b_op  = (opcode == OP_ADD) ? rsrc : ~rsrc;
    sum   = {1'b0, rdest} + {1'b0, b_op} + {{WIDTH{1'b0}}, opcode != OP_ADD};
    ovf   = (rdest[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != rdest[WIDTH-1]);
    rel_z = (rdest == rsrc);
    rel_l = (rdest < rsrc);
    rel_n = ($signed(rdest) < $signed(rsrc));

    if (op_q == OP_LSH)      sh_next = {sh_q[WIDTH-2:0], 1'b0};
    else if (op_q == OP_RSH) sh_next = {1'b0, sh_q[WIDTH-1:1]};
    else                     sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};

    mul_add = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mc_q})
                        : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    mc_d    = mc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    flags_d = flags_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = opcode;
          sh_d    = rsrc;
          mc_d    = rdest;
          state_d = DONE;
          valid_d = 1'b1;
          case (opcode)
            OP_ADD, OP_SUB: begin
              data_d  = sum[WIDTH-1:0];
              flags_d = {rel_n, rel_z, ovf, rel_l, sum[WIDTH]};
            end
            OP_CMP: flags_d = {rel_n, rel_z, 1'b0, rel_l, 1'b0};
            OP_AND: data_d = rsrc & rdest;
            OP_OR:  data_d = rsrc | rdest;
            OP_XOR: data_d = rsrc ^ rdest;
            OP_NOT: data_d = ~rsrc;
            OP_LSH, OP_RSH, OP_ARSH: begin
              if (shamt == '0) begin
                data_d = rsrc;
              end else begin
                state_d = SHIFT;
                valid_d = 1'b0;
                cnt_d   = {1'b0, shamt};
              end
            end
            OP_MUL: begin
              state_d = MUL;
              valid_d = 1'b0;
              cnt_d   = CNT_W'(WIDTH);
              prod_d  = {{WIDTH{1'b0}}, rsrc};
            end
            default: begin
              data_d = '0;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          data_d  = sh_next;
          state_d = DONE;
          valid_d = 1'b1;
        end
      end
      MUL: begin
        prod_d = {mul_add, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          data_d     = prod_d[WIDTH-1:0];
          flags_d[0] = |prod_d[2*WIDTH-1:WIDTH];
          flags_d[3] = (prod_d[WIDTH-1:0] == '0);
          state_d    = DONE;
          valid_d    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      sh_q    <= '0;
      mc_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      mc_q    <= mc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign op_err    = err_q;
  assign out_data  = data_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq against an arithmetic reference
// model of results, flags and completion latency.
module tb_alu_seq;
  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [4:0]    opcode = '0;
  logic [W-1:0]  rsrc = '0;
  logic [W-1:0]  rdest = '0;
  logic [SW-1:0] shamt = '0;
  logic          in_ready, out_valid, op_err;
  logic [W-1:0]  out_data;
  logic [4:0]    flags;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]  m_data  = '0;
  logic [4:0]    m_flags = '0;

  alu_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rsrc(rsrc), .rdest(rdest), .shamt(shamt),
    .out_valid(out_valid), .out_data(out_data), .flags(flags), .op_err(op_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: flags are {N,Z,F,L,C}; latency counts the accept edge as 1.
  task automatic model(input logic [4:0] op, input logic [W-1:0] d, input logic [W-1:0] s,
                       input logic [SW-1:0] k, output int lat, output logic err);
    int sd, ss, r;
    longint u;
    logic signed [W-1:0] a;
    sd  = $signed(d);
    ss  = $signed(s);
    lat = 1;
    err = 1'b0;
    case (op)
      5'd0, 5'd1, 5'd2: begin
        m_flags[3] = (d == s);
        m_flags[1] = (d < s);
        m_flags[4] = (sd < ss);
        if (op == 5'd0) begin
          u = longint'(d) + longint'(s);
          r = sd + ss;
          m_data     = u[W-1:0];
          m_flags[0] = u[W];
          m_flags[2] = (r > 32767) || (r < -32768);
        end else if (op == 5'd1) begin
          r = sd - ss;
          m_data     = d - s;
          m_flags[0] = (d >= s);
          m_flags[2] = (r > 32767) || (r < -32768);
        end else begin
          m_flags[0] = 1'b0;
          m_flags[2] = 1'b0;
        end
      end
      5'd3: m_data = s & d;
      5'd4: m_data = s | d;
      5'd5: m_data = s ^ d;
      5'd6: m_data = ~s;
      5'd7, 5'd8, 5'd9: begin
        a = s;
        if (op == 5'd7)      m_data = s << k;
        else if (op == 5'd8) m_data = s >> k;
        else                 m_data = a >>> k;
        lat = int'(k) + 1;
      end
      5'd10: begin
        u = longint'(d) * longint'(s);
        m_data     = u[W-1:0];
        m_flags[0] = (u[2*W-1:W] != 0);
        m_flags[3] = (u[W-1:0] == 0);
        lat = W + 1;
      end
      default: begin
        m_data = '0;
        err    = 1'b1;
      end
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_op(input logic [4:0] op, input logic [W-1:0] d, input logic [W-1:0] s,
                       input logic [SW-1:0] k, input string tag);
    int lat_exp, lat;
    logic err_exp;
    logic [W-1:0] prev_data;
    logic [4:0] prev_flags;
    bit seen, busy_ok, hold_ok;
    prev_data  = m_data;
    prev_flags = m_flags;
    model(op, d, s, k, lat_exp, err_exp);
    opcode = op; rdest = d; rsrc = s; shamt = k; in_valid = 1'b1;
    lat = 0; seen = 0; busy_ok = 1; hold_ok = 1;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) begin
        seen = 1;
      end else begin
        if (in_ready !== 1'b0) busy_ok = 0;
        if (out_data !== prev_data || flags !== prev_flags) hold_ok = 0;
        in_valid = 1'($urandom_range(0, 1));
        opcode   = 5'($urandom);
        rsrc     = W'($urandom);
        rdest    = W'($urandom);
        shamt    = SW'($urandom);
      end
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, lat_exp);
    chk({tag, "_data"}, out_data, m_data);
    chk({tag, "_flags"}, flags, m_flags);
    chk({tag, "_op_err"}, op_err, err_exp);
    if (lat_exp > 1) begin
      chk({tag, "_busy_not_ready"}, busy_ok, 1);
      chk({tag, "_busy_hold"}, hold_ok, 1);
    end
    @(negedge clk);
    chk({tag, "_pulse_end"}, {out_valid, op_err, in_ready}, 3'b001);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bit ov_seen;
    logic [4:0] rop;

    #3;
    chk("reset_ready", in_ready, 1);
    chk("reset_pulses", {out_valid, op_err}, 2'b00);
    chk("reset_data", out_data, 0);
    chk("reset_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(5'd0, 16'h7FFF, 16'h0001, 4'd0, "add_ovf");
    chk("add_ovf_lit", {out_data, flags[2], flags[0], flags[3]}, {16'h8000, 3'b100});
    do_op(5'd3, 16'h00FF, 16'h0F0F, 4'd0, "and");
    chk("and_lit", {out_data, flags[2]}, {16'h000F, 1'b1});
    do_op(5'd1, 16'h0003, 16'h0005, 4'd0, "sub");
    chk("sub_lit", {out_data, flags}, {16'hFFFE, 5'b10010});
    do_op(5'd2, 16'h1234, 16'h1234, 4'd0, "cmp_eq");
    chk("cmp_lit", {out_data, flags}, {16'hFFFE, 5'b01000});
    do_op(5'd9, 16'h0000, 16'h8004, 4'd3, "arsh3");
    chk("arsh3_lit", out_data, 16'hF000);
    do_op(5'd8, 16'h0000, 16'h8004, 4'd3, "rsh3");
    chk("rsh3_lit", out_data, 16'h1000);
    do_op(5'd9, 16'h0000, 16'h8004, 4'd0, "arsh0");
    chk("arsh0_lit", out_data, 16'h8004);
    do_op(5'd7, 16'h0000, 16'h8005, 4'd15, "lsh15");
    do_op(5'd10, 16'h0100, 16'h0100, 4'd0, "mul_hi");
    chk("mul_hi_lit", {out_data, flags[0], flags[3]}, {16'h0000, 2'b11});
    do_op(5'd10, 16'h0003, 16'h0005, 4'd0, "mul_small");
    chk("mul_small_lit", {out_data, flags[0]}, {16'h000F, 1'b0});
    do_op(5'd10, 16'hFFFF, 16'hFFFF, 4'd0, "mul_max");
    do_op(5'd20, 16'h1111, 16'h2222, 4'd0, "undef");
    do_op(5'd6, 16'h0000, 16'h00F0, 4'd0, "not");
    chk("not_lit", out_data, 16'hFF0F);
    do_op(5'd0, 16'hFFFF, 16'h0001, 4'd0, "add_carry");

    // Abort a MUL in flight with an asynchronous reset.
    opcode = 5'd10; rdest = 16'h0003; rsrc = 16'h0005; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {in_ready, out_valid, op_err}, 3'b100);
    chk("midreset_data", out_data, 0);
    chk("midreset_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_data = '0;
    m_flags = '0;
    ov_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_seen = 1;
    end
    chk("midreset_no_valid", ov_seen, 0);

    for (int i = 0; i < 150; i++) begin
      rop = 5'($urandom_range(0, 12));
      if (rop > 5'd10) rop = 5'($urandom_range(11, 31));
      do_op(rop, pick_val(), pick_val(), SW'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Adds a valid/ready operand handshake, a registered result, and a persistent flag register (C,L,F,Z,N) that only flag-writing ops update.
- Adds variable-amount shifts (one bit per cycle) and an iterative shift-add multiply.
- Sits between the register file read ports and the writeback mux; the control FSM stalls on in_ready.

Parameters:
WIDTH, 16, datapath width in bits (power of two, >=8)
SHAMT_W, 4, shift-amount width; must equal log2(WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block idle, can accept an operation
opcode  input  5  ADD=0,SUB=1,CMP=2,AND=3,OR=4,XOR=5,NOT=6,LSH=7,RSH=8,ARSH=9,MUL=10
rsrc  input  WIDTH  source operand
rdest  input  WIDTH  destination operand
shamt  input  SHAMT_W  shift distance for LSH/RSH/ARSH
out_valid  output  1  one-cycle pulse: out_data/flags updated this cycle
out_data  output  WIDTH  registered result; holds until next non-CMP completion
flags  output  5  registered {N,Z,F,L,C} = bits [4:0] as N=4,Z=3,F=2,L=1,C=0
op_err  output  1  one-cycle pulse with out_valid for an undefined opcode

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; op_err=0; out_data=0; flags=0. Reset mid-operation aborts; no completion pulse.
- States: IDLE, SHIFT, MUL, DONE. Accept = in_valid & in_ready (in_ready=1 only in IDLE). Opcode, rsrc, rdest and shamt are latched on accept; later input changes are ignored. in_valid while busy is ignored, not queued.
- Single-cycle ops (ADD,SUB,CMP,AND,OR,XOR,NOT, undefined): IDLE->DONE. out_valid is asserted the cycle after accept (latency 1). DONE->IDLE unconditionally, so back-to-back throughput is one op per 2 cycles.
- ADD: result = rdest+rsrc mod 2^WIDTH. C = carry out. F = signed overflow. Z = (rdest==rsrc). L = unsigned rdest<rsrc. N = signed rdest<rsrc. All five flags written.
- SUB: result = rdest-rsrc, computed as rdest+~rsrc+1. C = carry out of that sum (1 = no borrow). F = signed overflow of rdest-rsrc. Z, L, N as for ADD.
- CMP: flags C=0, F=0; L, Z, N as for ADD. out_data is not changed; out_valid still pulses.
- AND/OR/XOR: bitwise rsrc op rdest. NOT: bitwise ~rsrc (not logical). Flags unchanged.
- LSH/RSH/ARSH operate on rsrc. shamt=0: IDLE->DONE, result=rsrc, latency 1. shamt=k>0: IDLE->SHIFT, one bit per cycle for k cycles, then DONE; latency k+1. RSH fills with 0; ARSH replicates the MSB; LSH fills the LSB with 0. Flags unchanged.
- MUL: unsigned rdest*rsrc via shift-add, one multiplier bit per cycle. IDLE->MUL for WIDTH cycles, then DONE; latency WIDTH+1. out_data = low WIDTH bits. C = 1 iff the high WIDTH bits are nonzero. Z = (low half==0). L, F, N unchanged.
- Undefined opcode (11..31): out_data=0, flags unchanged, op_err=1 together with out_valid, latency 1.
- out_valid and op_err are high for exactly one cycle (state DONE). out_data and flags change only at that edge.

Test Plan:
- Reset: assert rst_n=0 during a MUL in progress -> immediately in_ready=1, out_data=0, flags=0; no out_valid after release.
- ADD 0x7FFF+0x0001 -> out_data=0x8000, F=1, C=0, Z=0. Then AND 0x00FF&0x0F0F -> out_data=0x000F with flags unchanged (F still 1).
- SUB rdest=0x0003,rsrc=0x0005 -> out_data=0xFFFE, C=0, L=1, N=1, Z=0. Then CMP equal operands 0x1234/0x1234 -> Z=1, C=0, F=0, out_data stays 0xFFFE.
- ARSH rsrc=0x8004, shamt=3 -> out_valid exactly 4 cycles after accept, out_data=0xF000. RSH same operands -> 0x1000. shamt=0 -> 0x8004 after 1 cycle.
- MUL 0x0100*0x0100 -> latency 17 cycles, out_data=0x0000, C=1, Z=1. MUL 0x0003*0x0005 -> 0x000F, C=0. in_valid pulses during busy are ignored (in_ready=0).
- opcode=5'd20 -> out_valid and op_err high for one cycle, out_data=0, flags unchanged. Then NOT 0x00F0 -> 0xFF0F.
